// File: rtl/pixel_row_readout_pkg.sv
// Shared sensor geometry, row-buffer entry layout and serialiser state encoding.
// Everything that agrees on pixel/row widths imports this package.
package PixelSensorConfig;

    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int PIXEL_BITS         = 8;

    localparam int ROW_IDX_BITS = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int COL_IDX_BITS = $clog2(PIXEL_ARRAY_WIDTH);

    typedef struct packed {
        logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] data;
        logic [ROW_IDX_BITS-1:0]                 row;
    } row_entry_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/pixel_row_readout_if.sv
// Pixel stream from the readout block to the frame sink: one pixel per valid/ready transfer.
// master drives pixel, coordinates and frame markers; slave returns ready.
interface pixel_row_readout_if
    import PixelSensorConfig::*;
#(
    parameter int PIX_W = PIXEL_BITS,
    parameter int ROW_W = ROW_IDX_BITS,
    parameter int COL_W = COL_IDX_BITS
);
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             out_sof;
    logic             out_eof;

    modport master (
        output out_valid, out_pixel, out_row, out_col, out_sof, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pixel, out_row, out_col, out_sof, out_eof,
        output out_ready
    );
endinterface

// File: rtl/pixel_row_readout_row_fifo.sv
// Circular synchronous FIFO of whole-row entries; head is visible combinationally, one-cycle write-to-head.
// Backpressure: a push is accepted while full only if a pop happens in the same cycle.
module row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Explicit wrap keeps non-power-of-two depths and DEPTH=1 correct.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_row_readout.sv
// Captures selected sensor rows into a row FIFO and serialises them one pixel per transfer; first pixel valid the cycle after capture.
// Backpressure: out_ready low holds all outputs; rows arriving while the buffer stays full are dropped and flagged.
module pixel_row_readout #(
    parameter int PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_BITS         = PixelSensorConfig::PIXEL_BITS,
    parameter int ROW_BUF_DEPTH      = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    new_row,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]           p_row_select,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] p_data,
    pixel_row_readout_if.master                     stream,
    output logic                                    overrun,
    output logic                                    select_error
);
    import PixelSensorConfig::*;

    localparam int RB = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int CB = $clog2(PIXEL_ARRAY_WIDTH);
    localparam int CW = $clog2(ROW_BUF_DEPTH+1);

    ser_state_t    state;
    logic [CB-1:0] col;
    logic          row_onehot;
    logic [RB-1:0] row_enc;
    row_entry_t    push_entry;
    row_entry_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_next;
    logic          valid;
    logic          xfer;
    logic          last_col;
    logic          pop;
    logic          push_ok;
    logic          capture;

    always_comb begin
        row_enc = '0;
        for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
            if (p_row_select[i]) begin
                row_enc = row_enc | RB'(i);
            end
        end
    end

    assign row_onehot      = $onehot(p_row_select);
    assign capture         = new_row && row_onehot;
    assign push_entry.data = p_data;
    assign push_entry.row  = row_enc;

    assign valid    = (state == S_STREAM);
    assign xfer     = valid && stream.out_ready;
    assign last_col = (col == CB'(PIXEL_ARRAY_WIDTH-1));
    assign pop      = xfer && last_col && !fifo_empty;
    // A full buffer still takes the new row when the head row finishes this cycle.
    assign push_ok  = capture && (!fifo_full || pop);
    assign cnt_next = fifo_count + CW'(push_ok) - CW'(pop);

    row_fifo #(
        .DEPTH (ROW_BUF_DEPTH),
        .WIDTH ($bits(row_entry_t))
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            col          <= '0;
            overrun      <= 1'b0;
            select_error <= 1'b0;
        end else begin
            state <= (cnt_next != '0) ? S_STREAM : S_IDLE;
            if (xfer) begin
                col <= last_col ? '0 : col + CB'(1);
            end
            if (capture && fifo_full && !pop) begin
                overrun <= 1'b1;
            end
            if (new_row && !row_onehot) begin
                select_error <= 1'b1;
            end
        end
    end

    // Gated with valid so an idle block presents all-zero outputs.
    assign stream.out_valid = valid;
    assign stream.out_pixel = valid ? head.data[col*PIXEL_BITS +: PIXEL_BITS] : '0;
    assign stream.out_row   = valid ? head.row : '0;
    assign stream.out_col   = valid ? col : '0;
    assign stream.out_sof   = valid && (head.row == '0) && (col == '0);
    assign stream.out_eof   = valid && (head.row == RB'(PIXEL_ARRAY_HEIGHT-1)) && last_col;
endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout at W=4, H=2, 8-bit pixels, two-row buffer.
// Expected pixels are queued at capture time and checked by a transfer monitor.
module tb_pixel_row_readout;
    import PixelSensorConfig::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_row;
    logic [1:0]  p_row_select;
    logic [31:0] p_data;
    logic        overrun;
    logic        select_error;

    always #5 clk = ~clk;

    pixel_row_readout_if stream ();

    pixel_row_readout #(
        .PIXEL_ARRAY_WIDTH  (4),
        .PIXEL_ARRAY_HEIGHT (2),
        .PIXEL_BITS         (8),
        .ROW_BUF_DEPTH      (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .new_row      (new_row),
        .p_row_select (p_row_select),
        .p_data       (p_data),
        .stream       (stream),
        .overrun      (overrun),
        .select_error (select_error)
    );

    typedef struct packed {
        logic [7:0] pixel;
        logic       row;
        logic [1:0] col;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    exp_t want;
    int   checks = 0;
    int   fails  = 0;
    int   n_xfer = 0;
    int   n_eof  = 0;

    always @(negedge clk) begin
        if (!reset && stream.out_valid && stream.out_ready) begin
            got = {stream.out_pixel, stream.out_row, stream.out_col, stream.out_sof, stream.out_eof};
            n_xfer++;
            if (stream.out_eof) n_eof++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL xfer_unexpected: got pixel=%h row=%0d col=%0d, required no transfer",
                         got.pixel, got.row, got.col);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL xfer_data: got pix=%h row=%0d col=%0d sof=%b eof=%b, required pix=%h row=%0d col=%0d sof=%b eof=%b",
                             got.pixel, got.row, got.col, got.sof, got.eof,
                             want.pixel, want.row, want.col, want.sof, want.eof);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] data, input logic [1:0] sel);
        new_row      = 1'b1;
        p_row_select = sel;
        p_data       = data;
        tick();
        new_row      = 1'b0;
        p_row_select = 2'b00;
    endtask

    task automatic expect_row(input logic [31:0] data, input logic row);
        exp_t e;
        logic [31:0] d;
        d = data;
        for (int c = 0; c < 4; c++) begin
            e.pixel = d[c*8 +: 8];
            e.row   = row;
            e.col   = 2'(c);
            e.sof   = (row == 1'b0) && (c == 0);
            e.eof   = (row == 1'b1) && (c == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        stream.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [16:0] all_outputs();
        return {stream.out_valid, stream.out_pixel, stream.out_row, stream.out_col,
                stream.out_sof, stream.out_eof, overrun, select_error};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        checks++;
        if (all_outputs() !== 17'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", all_outputs());
        end
        reset = 1'b0;
        tick();
        checks++;
        if (all_outputs() !== 17'h0) begin
            fails++;
            $display("FAIL idle_outputs: got %h, required 0", all_outputs());
        end
    endtask

    task automatic test_single_row();
        int base;
        do_reset();
        base = n_xfer;
        stream.out_ready = 1'b1;
        expect_row(32'h04030201, 1'b0);
        capture(32'h04030201, 2'b01);
        checks++;
        if ({stream.out_valid, stream.out_pixel, stream.out_col, stream.out_sof} !== {1'b1, 8'h01, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL first_pixel_latency: got valid=%b pix=%h col=%0d sof=%b, required valid=1 pix=01 col=0 sof=1",
                     stream.out_valid, stream.out_pixel, stream.out_col, stream.out_sof);
        end
        repeat (4) tick();
        checks++;
        if (stream.out_valid !== 1'b0 || (n_xfer - base) != 4) begin
            fails++;
            $display("FAIL single_row_len: got valid=%b xfers=%0d, required valid=0 xfers=4",
                     stream.out_valid, n_xfer - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int eof_base;
        do_reset();
        base     = n_xfer;
        eof_base = n_eof;
        stream.out_ready = 1'b1;
        expect_row(32'h04030201, 1'b0);
        expect_row(32'h08070605, 1'b1);
        capture(32'h04030201, 2'b01);
        capture(32'h08070605, 2'b10);
        repeat (7) tick();
        checks++;
        if ((n_xfer - base) != 8 || stream.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_count: got xfers=%0d valid=%b, required xfers=8 valid=0",
                     n_xfer - base, stream.out_valid);
        end
        checks++;
        if ((n_eof - eof_base) != 1) begin
            fails++;
            $display("FAIL b2b_eof_count: got %0d, required 1", n_eof - eof_base);
        end
    endtask

    task automatic test_overrun();
        int base;
        do_reset();
        base = n_xfer;
        expect_row(32'h14131211, 1'b0);
        capture(32'h14131211, 2'b01);
        expect_row(32'h24232221, 1'b1);
        capture(32'h24232221, 2'b10);
        checks++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_early: got %b, required 0", overrun);
        end
        capture(32'h34333231, 2'b01);
        checks++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        tick();
        tick();
        checks++;
        if ({stream.out_valid, stream.out_pixel, stream.out_col} !== {1'b1, 8'h11, 2'd0}) begin
            fails++;
            $display("FAIL hold_stable: got valid=%b pix=%h col=%0d, required valid=1 pix=11 col=0",
                     stream.out_valid, stream.out_pixel, stream.out_col);
        end
        stream.out_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if ((n_xfer - base) != 8 || exp_q.size() != 0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_drain: got xfers=%0d pending=%0d overrun=%b, required xfers=8 pending=0 overrun=1",
                     n_xfer - base, exp_q.size(), overrun);
        end
    endtask

    task automatic test_full_push_pop();
        int base;
        do_reset();
        expect_row(32'h44434241, 1'b0);
        capture(32'h44434241, 2'b01);
        expect_row(32'h54535251, 1'b1);
        capture(32'h54535251, 2'b10);
        base = n_xfer;
        stream.out_ready = 1'b1;
        repeat (3) tick();
        expect_row(32'h64636261, 1'b0);
        capture(32'h64636261, 2'b01);
        checks++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL full_push_pop_overrun: got %b, required 0", overrun);
        end
        repeat (8) tick();
        checks++;
        if ((n_xfer - base) != 12 || exp_q.size() != 0 || stream.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_push_pop_drain: got xfers=%0d pending=%0d valid=%b, required xfers=12 pending=0 valid=0",
                     n_xfer - base, exp_q.size(), stream.out_valid);
        end
    endtask

    task automatic test_select_error();
        int base;
        do_reset();
        base = n_xfer;
        stream.out_ready = 1'b1;
        capture(32'h77777777, 2'b11);
        checks++;
        if (select_error !== 1'b1 || stream.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL select_multi_hot: got err=%b valid=%b, required err=1 valid=0",
                     select_error, stream.out_valid);
        end
        do_reset();
        stream.out_ready = 1'b1;
        capture(32'h88888888, 2'b00);
        tick();
        checks++;
        if (select_error !== 1'b1 || stream.out_valid !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL select_zero: got err=%b valid=%b overrun=%b, required err=1 valid=0 overrun=0",
                     select_error, stream.out_valid, overrun);
        end
        checks++;
        if ((n_xfer - base) != 0) begin
            fails++;
            $display("FAIL select_nothing_queued: got xfers=%0d, required 0", n_xfer - base);
        end
    endtask

    task automatic test_reset_midrow();
        int base;
        do_reset();
        base = n_xfer;
        stream.out_ready = 1'b1;
        expect_row(32'h94939291, 1'b0);
        capture(32'h94939291, 2'b01);
        tick();
        tick();
        checks++;
        if ((n_xfer - base) != 2) begin
            fails++;
            $display("FAIL midrow_progress: got xfers=%0d, required 2", n_xfer - base);
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
        checks++;
        if (all_outputs() !== 17'h0) begin
            fails++;
            $display("FAIL midrow_reset_outputs: got %h, required 0", all_outputs());
        end
        reset = 1'b0;
        base = n_xfer;
        expect_row(32'hA4A3A2A1, 1'b1);
        capture(32'hA4A3A2A1, 2'b10);
        checks++;
        if ({stream.out_valid, stream.out_pixel, stream.out_row, stream.out_col} !== {1'b1, 8'hA1, 1'b1, 2'd0}) begin
            fails++;
            $display("FAIL after_reset_col0: got valid=%b pix=%h row=%0d col=%0d, required valid=1 pix=a1 row=1 col=0",
                     stream.out_valid, stream.out_pixel, stream.out_row, stream.out_col);
        end
        repeat (4) tick();
        checks++;
        if ((n_xfer - base) != 4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL after_reset_drain: got xfers=%0d pending=%0d, required xfers=4 pending=0",
                     n_xfer - base, exp_q.size());
        end
    endtask

    initial begin
        reset            = 1'b1;
        new_row          = 1'b0;
        p_row_select     = 2'b00;
        p_data           = 32'h0;
        stream.out_ready = 1'b0;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_overrun();
        test_full_push_pop();
        test_select_error();
        test_reset_midrow();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
